// File: rtl/rmt_recovery_sequencer.sv
// Write-port owner for the 6-write speculative rename map table: rename passthrough,
// or a 6-entry-per-cycle restore from the AMT on mispredict. Optional counters: RMT_RECOVERY_STATS_EN.
module rmt_recovery_sequencer #(
  parameter int RMT_DEPTH = 32,
  parameter int RMT_INDEX = 5,
  parameter int PHY_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   recover_i,
  input  logic [5:0]             ren_we_i,
  input  logic [6*RMT_INDEX-1:0] ren_addr_i,
  input  logic [6*PHY_WIDTH-1:0] ren_data_i,
  output logic [6*RMT_INDEX-1:0] amt_addr_o,
  input  logic [6*PHY_WIDTH-1:0] amt_data_i,
  output logic [5:0]             rmt_we_o,
  output logic [6*RMT_INDEX-1:0] rmt_addr_o,
  output logic [6*PHY_WIDTH-1:0] rmt_data_o,
  output logic                   stall_o,
  output logic                   done_o
`ifdef RMT_RECOVERY_STATS_EN
  ,
  output logic [15:0]            recover_cnt_o,
  output logic [31:0]            stall_cyc_o
`endif
);

  localparam int LANES = 6;
  localparam int EW    = RMT_INDEX + 1;

  // state   | meaning
  // IDLE    | rename writes pass straight through
  // RECOVER | one beat of the AMT -> RMT copy per cycle
  // DONE    | restore complete, done_o pulse
  typedef enum logic [1:0] {IDLE, RECOVER, DONE} state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] base_q, base_d;
  logic [EW-1:0] e;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    e          = '0;
    rmt_we_o   = '0;
    rmt_addr_o = '0;
    rmt_data_o = '0;
    amt_addr_o = '0;
    done_o     = 1'b0;
    case (state_q)
      IDLE: begin
        // a recover request squashes this cycle's rename writes
        rmt_we_o   = recover_i ? 6'b0 : ren_we_i;
        rmt_addr_o = ren_addr_i;
        rmt_data_o = ren_data_i;
        if (recover_i) begin
          state_d = RECOVER;
          base_d  = '0;
        end
      end
      RECOVER: begin
        for (int k = 0; k < LANES; k++) begin
          e = base_q + EW'(k);
          rmt_data_o[k*PHY_WIDTH +: PHY_WIDTH] = amt_data_i[k*PHY_WIDTH +: PHY_WIDTH];
          if (32'(e) < RMT_DEPTH) begin
            amt_addr_o[k*RMT_INDEX +: RMT_INDEX] = e[RMT_INDEX-1:0];
            rmt_addr_o[k*RMT_INDEX +: RMT_INDEX] = e[RMT_INDEX-1:0];
            rmt_we_o[k]                          = 1'b1;
          end
        end
        if (recover_i) begin
          base_d = '0;
        end else if (32'(base_q) + LANES >= RMT_DEPTH) begin
          state_d = DONE;
          base_d  = '0;
        end else begin
          base_d = base_q + EW'(LANES);
        end
      end
      DONE: begin
        done_o  = 1'b1;
        base_d  = '0;
        state_d = recover_i ? RECOVER : IDLE;
      end
      default: begin
        state_d = IDLE;
        base_d  = '0;
      end
    endcase
  end

  assign stall_o = (state_q != IDLE);

`ifdef RMT_RECOVERY_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      recover_cnt_o <= '0;
      stall_cyc_o   <= '0;
    end else begin
      if (recover_i && recover_cnt_o != 16'hFFFF)
        recover_cnt_o <= recover_cnt_o + 16'd1;
      if (stall_o && stall_cyc_o != 32'hFFFF_FFFF)
        stall_cyc_o <= stall_cyc_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rmt_recovery_sequencer.sv
// Directed bench for rmt_recovery_sequencer: a 32-entry instance plus a 34-entry
// instance, with combinational AMT models (AMT[i] = i+40) and RMT shadow arrays.
module tb_rmt_recovery_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        recover = 1'b0;
  logic        recover2 = 1'b0;
  logic        clr = 1'b0;
  logic [5:0]  ren_we = '0;
  logic [29:0] ren_addr = '0;
  logic [41:0] ren_data = '0;
  logic [29:0] amt_addr, rmt_addr;
  logic [41:0] amt_data, rmt_data;
  logic [5:0]  rmt_we;
  logic        stall, done;

  logic [5:0]  ren_we2 = '0;
  logic [35:0] ren_addr2 = '0;
  logic [41:0] ren_data2 = '0;
  logic [35:0] amt_addr2, rmt_addr2;
  logic [41:0] amt_data2, rmt_data2;
  logic [5:0]  rmt_we2;
  logic        stall2, done2;

`ifdef RMT_RECOVERY_STATS_EN
  logic [15:0] recover_cnt, recover_cnt2;
  logic [31:0] stall_cyc, stall_cyc2;
`endif

  logic [6:0] rmt_m  [0:63];
  logic [6:0] rmt_m2 [0:63];
  logic       seen_done;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rmt_recovery_sequencer dut (
    .clk(clk), .reset(reset), .recover_i(recover),
    .ren_we_i(ren_we), .ren_addr_i(ren_addr), .ren_data_i(ren_data),
    .amt_addr_o(amt_addr), .amt_data_i(amt_data),
    .rmt_we_o(rmt_we), .rmt_addr_o(rmt_addr), .rmt_data_o(rmt_data),
    .stall_o(stall), .done_o(done)
`ifdef RMT_RECOVERY_STATS_EN
    , .recover_cnt_o(recover_cnt), .stall_cyc_o(stall_cyc)
`endif
  );

  rmt_recovery_sequencer #(.RMT_DEPTH(34), .RMT_INDEX(6), .PHY_WIDTH(7)) dut2 (
    .clk(clk), .reset(reset), .recover_i(recover2),
    .ren_we_i(ren_we2), .ren_addr_i(ren_addr2), .ren_data_i(ren_data2),
    .amt_addr_o(amt_addr2), .amt_data_i(amt_data2),
    .rmt_we_o(rmt_we2), .rmt_addr_o(rmt_addr2), .rmt_data_o(rmt_data2),
    .stall_o(stall2), .done_o(done2)
`ifdef RMT_RECOVERY_STATS_EN
    , .recover_cnt_o(recover_cnt2), .stall_cyc_o(stall_cyc2)
`endif
  );

  always_comb begin
    amt_data  = '0;
    amt_data2 = '0;
    for (int k = 0; k < 6; k++) begin
      amt_data[k*7 +: 7]  = 7'(amt_addr[k*5 +: 5]) + 7'd40;
      amt_data2[k*7 +: 7] = 7'(amt_addr2[k*6 +: 6]) + 7'd40;
    end
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) begin
        rmt_m[i]  <= '0;
        rmt_m2[i] <= '0;
      end
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (rmt_we[k])  rmt_m[rmt_addr[k*5 +: 5]]   <= rmt_data[k*7 +: 7];
        if (rmt_we2[k]) rmt_m2[rmt_addr2[k*6 +: 6]] <= rmt_data2[k*7 +: 7];
      end
    end
  end

  // the 34-entry table must never see a write beyond its last entry
  always @(negedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (rmt_we2[k]) begin
        checks++;
        assert (rmt_addr2[k*6 +: 6] < 6'd34) else begin
          errors++;
          $error("FAIL d34_addr_range lane %0d got=%0d exp=<34", k, rmt_addr2[k*6 +: 6]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    tick;
    tick;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(rmt_we), 32'd0);
    check("rst_amt_addr", 32'(amt_addr), 32'd0);
    check("rst_stall2", 32'(stall2), 32'd0);
    reset = 1'b0;

    // passthrough
    ren_we   = 6'b101101;
    ren_addr = {5'd31, 5'd20, 5'd9, 5'd8, 5'd7, 5'd3};
    ren_data = {7'h55, 7'h44, 7'h33, 7'h22, 7'h11, 7'h12};
    #1;
    check("pt_we", 32'(rmt_we), 32'b101101);
    check("pt_addr0", 32'(rmt_addr[4:0]), 32'd3);
    check("pt_data0", 32'(rmt_data[6:0]), 32'h12);
    check("pt_addr5", 32'(rmt_addr[29:25]), 32'd31);
    check("pt_data5", 32'(rmt_data[41:35]), 32'h55);
    check("pt_stall", 32'(stall), 32'd0);
    clr = 1'b1;
    tick;
    clr = 1'b0;

    // full restore, cycle 0
    ren_we   = 6'h3F;
    recover  = 1'b1;
    recover2 = 1'b1;
    #1;
    check("fr_c0_we", 32'(rmt_we), 32'd0);
    check("fr_c0_stall", 32'(stall), 32'd0);
    tick;
    recover  = 1'b0;
    recover2 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check("fr_stall", 32'(stall), 32'd1);
      check("fr_done", 32'(done), 32'd0);
      check("fr_amt0", 32'(amt_addr[4:0]), 32'(6*(c-1)));
      check("fr_we", 32'(rmt_we), (c == 6) ? 32'b000011 : 32'h3F);
      check("fr_data1", 32'(rmt_data[13:7]), 32'(6*(c-1) + 41));
      check("d34_amt0", 32'(amt_addr2[5:0]), 32'(6*(c-1)));
      check("d34_we", 32'(rmt_we2), (c == 6) ? 32'b001111 : 32'h3F);
      tick;
    end
    check("fr_c7_done", 32'(done), 32'd1);
    check("fr_c7_stall", 32'(stall), 32'd1);
    check("fr_c7_we", 32'(rmt_we), 32'd0);
    check("d34_c7_done", 32'(done2), 32'd1);
    tick;
    check("fr_c8_stall", 32'(stall), 32'd0);
    check("fr_c8_done", 32'(done), 32'd0);
    check("fr_c8_we", 32'(rmt_we), 32'h3F);
    check("fr_c8_addr0", 32'(rmt_addr[4:0]), 32'd3);
    for (int i = 0; i < 32; i++) check("fr_rmt", 32'(rmt_m[i]), 32'(i + 40));
    for (int i = 0; i < 34; i++) check("d34_rmt", 32'(rmt_m2[i]), 32'(i + 40));
    ren_we = '0;

    // restart at the base=12 beat
    recover = 1'b1;
    tick;
    recover = 1'b0;
    tick;
    tick;
    recover = 1'b1;
    ren_we  = 6'h3F;
    #1;
    check("rs_c3_amt0", 32'(amt_addr[4:0]), 32'd12);
    check("rs_c3_we", 32'(rmt_we), 32'h3F);
    check("rs_c3_addr5", 32'(rmt_addr[29:25]), 32'd17);
    tick;
    recover = 1'b0;
    ren_we  = '0;
    check("rs_c4_amt0", 32'(amt_addr[4:0]), 32'd0);
    check("rs_c4_stall", 32'(stall), 32'd1);
    repeat (5) tick;
    check("rs_c9_done", 32'(done), 32'd0);
    check("rs_c9_amt0", 32'(amt_addr[4:0]), 32'd30);
    tick;
    check("rs_c10_done", 32'(done), 32'd1);
    tick;
    check("rs_c11_stall", 32'(stall), 32'd0);

    // reset in the middle of a copy
    recover = 1'b1;
    tick;
    recover = 1'b0;
    tick;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset  = 1'b0;
    ren_we = 6'b010101;
    #1;
    check("rm_c5_stall", 32'(stall), 32'd0);
    check("rm_c5_we", 32'(rmt_we), 32'b010101);
    check("rm_c5_done", 32'(done), 32'd0);
    seen_done = 1'b0;
    repeat (10) begin
      tick;
      seen_done = seen_done | done;
    end
    check("rm_no_done", 32'(seen_done), 32'd0);
    ren_we = '0;

    // three back-to-back full recoveries
    for (int r = 0; r < 3; r++) begin
      recover = 1'b1;
      tick;
      recover = 1'b0;
      repeat (6) tick;
      check("tr_done", 32'(done), 32'd1);
      tick;
      check("tr_idle", 32'(stall), 32'd0);
    end
`ifdef RMT_RECOVERY_STATS_EN
    check("st_recover_cnt", 32'(recover_cnt), 32'd3);
    check("st_stall_cyc", stall_cyc, 32'd21);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rmt_recovery_sequencer.md
Name: rmt_recovery_sequencer

Overview:
- Owns the 6 write ports of the 12R6W speculative rename map table (RMT).
- In normal operation it passes the 6 rename-lane writes straight through to the RMT.
- On a branch-mispredict recovery request it stalls rename. It then copies the architectural map table (AMT) into the RMT, 6 entries per cycle, using the AMT read ports.
- It sits between the rename stage, the AMT and the RMT SRAM.

Parameters:
RMT_DEPTH, 32, number of map-table entries (logical registers)
RMT_INDEX, 5, log2(RMT_DEPTH), entry address width
PHY_WIDTH, 7, physical-register tag width (RMT data width)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
recover_i  in  1  one-cycle pulse requesting RMT restore from AMT
ren_we_i  in  6  rename lane write enables, bit k = lane k
ren_addr_i  in  6*RMT_INDEX  rename lane write addresses, lane k at [k*RMT_INDEX +: RMT_INDEX]
ren_data_i  in  6*PHY_WIDTH  rename lane write tags, lane k at [k*PHY_WIDTH +: PHY_WIDTH]
amt_addr_o  out  6*RMT_INDEX  AMT read addresses, lane k
amt_data_i  in  6*PHY_WIDTH  AMT combinational read data, lane k
rmt_we_o  out  6  RMT write enables (to we0..we5)
rmt_addr_o  out  6*RMT_INDEX  RMT write addresses
rmt_data_o  out  6*PHY_WIDTH  RMT write data
stall_o  out  1  rename stall; high while recovery is in progress
done_o  out  1  one-cycle pulse: RMT restore complete

Behaviour:
- Clock and reset: clk; reset is synchronous and active-high. The state machine uses all-synchronous logic.
- Reset values: state=IDLE, base=0. With those values stall_o=0, done_o=0 and rmt_we_o=0. amt_addr_o is then 0 and don't-care.
- States: IDLE, RECOVER, DONE.
- IDLE:
  - rmt_we/addr/data = ren_we/addr/data, combinationally.
  - amt_addr_o = 0.
- recover_i in IDLE:
  - rmt_we_o is forced to 0 in that same cycle. Those rename writes belong to squashed instructions and are dropped.
  - Next state is RECOVER, with base=0.
- RECOVER (one beat per cycle):
  - For lane k, the entry is e = base+k.
  - amt_addr_o lane k = e.
  - rmt_addr_o lane k = e.
  - rmt_data_o lane k = amt_data_i lane k.
  - rmt_we_o[k] = (e < RMT_DEPTH).
  - Lanes with e >= RMT_DEPTH output address 0 with we=0. e is computed one bit wider than RMT_INDEX so it does not wrap.
  - base advances by 6 each beat.
  - When base+6 >= RMT_DEPTH (last beat), next state is DONE and base returns to 0.
  - Rename writes are ignored throughout RECOVER.
- DONE:
  - done_o=1 and rmt_we_o=0.
  - Next state is IDLE.
- stall_o = (state != IDLE). stall_o is 0 in the cycle recover_i first arrives, because the squash happens through the forced-zero writes.
- Latency: ceil(RMT_DEPTH/6) RECOVER beats plus 1 DONE cycle. With the defaults this is 6+1. If recover_i is at cycle 0, rename passthrough resumes at cycle 8.
- recover_i during RECOVER: the copy restarts, with base=0 on the next cycle, and the current beat's writes still occur. The AMT is unchanged by the squash, so this is a restart, not an error.
- recover_i during DONE: next state is RECOVER with base=0, and done_o is still pulsed this cycle.
- AMT contents must be stable during RECOVER. Commit is stalled externally, because stall_o also blocks retire.
- reset mid-RECOVER: next cycle is IDLE, all writes are 0, the partial copy is abandoned and there is no done_o.
- The whole copy takes 1-to-1 data; no arithmetic is applied to tags.

Optional Feature:
- Macro RMT_RECOVERY_STATS_EN.
- When defined, the block adds two outputs:
  - recover_cnt_o (16 bits): increments on each accepted recover_i, saturates at 16'hFFFF.
  - stall_cyc_o (32 bits): increments every cycle stall_o=1, saturates.
  - Both counters clear on reset.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Passthrough: IDLE, ren_we=6'b101101, lane0 addr=3 data=7'h12 -> same cycle rmt_we_o=6'b101101, lane0 addr 3 data 7'h12; stall_o=0.
- Full restore: AMT[i]=i+40, pulse recover_i at cycle 0 with ren_we=6'h3F -> rmt_we_o=0 at cycle 0. Cycles 1-6 show base 0,6,12,18,24,30. Cycle 6 rmt_we_o=6'b000011 (entries 30,31). done_o=1 at cycle 7, stall_o=1 at cycles 1-7. Afterwards RMT[i]=i+40 for all 32 entries.
- Restart: recover_i again at cycle 3 (base=12 beat) -> that beat writes 12-17, cycle 4 base=0, done_o at cycle 10.
- Reset mid-recovery: reset at cycle 4 -> cycle 5 IDLE, stall_o=0, rmt_we_o follows ren_we_i, done_o never asserts.
- Non-multiple depth: RMT_DEPTH=34 -> 6 beats, last beat base=30 with rmt_we_o=6'b001111. No write to address >= 34 ever occurs; check with an assertion.
- Stats (RMT_RECOVERY_STATS_EN): three full recoveries -> recover_cnt_o=3, stall_cyc_o=21.
